// File: rtl/round_robin.sv
// round_robin: FIFO pop arbiter that grants each FIFO up to its weight in pops per turn and skips empty FIFOs.
// Optional weighting is enabled by defining ROUNDROBIN_WEIGHT_EN; otherwise this is plain one-pop-per-turn round-robin.
module round_robin (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] request,
  input  logic [3:0]  empty,
  input  logic        read,
  output logic [1:0]  pop_id,
  output logic        valid
);
  logic [1:0]      cur_q, nxt;
  logic [4:0]      cnt_q, rem;
  logic [3:0][4:0] eff;
`ifdef ROUNDROBIN_WEIGHT_EN
  for (genvar i = 0; i < 4; i++) begin : g_eff
    assign eff[i] = (request[5*i +: 5] == 5'd0) ? 5'd1 : request[5*i +: 5];
  end
`else
  logic unused_req;
  assign unused_req = ^request;
  assign eff = {4{5'd1}};
`endif
  assign valid = ~&empty;
  // Scan from farthest to nearest so the nearest non-empty index after cur wins.
  always_comb begin
    pop_id = cur_q;
    for (int k = 3; k >= 0; k--)
      if (!empty[cur_q + k[1:0]]) pop_id = cur_q + k[1:0];
  end
  assign rem = (pop_id == cur_q) ? cnt_q : eff[pop_id];
  assign nxt = pop_id + 2'd1;
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q <= 2'd0;
      cnt_q <= eff[0];
    end else if (read && valid) begin
      cur_q <= (rem <= 5'd1) ? nxt : pop_id;
      cnt_q <= (rem <= 5'd1) ? eff[nxt] : rem - 5'd1;
    end
  end
endmodule

// File: tb/tb_round_robin.sv
// tb_round_robin: directed scenarios plus randomized traffic checked against a behavioural arbiter model.
module tb_round_robin;
  logic        clk = 0;
  logic        reset = 1;
  logic [19:0] request = '0;
  logic [3:0]  empty = 4'hf;
  logic        read = 0;
  logic [1:0]  pop_id;
  logic        valid;
  int n_pass = 0, n_total = 0;
  int m_cur = 0, m_cnt = 1;

  round_robin dut (.clk(clk), .reset(reset), .request(request), .empty(empty),
                   .read(read), .pop_id(pop_id), .valid(valid));

  always #5 clk = ~clk;

  function automatic int m_eff(input logic [19:0] req, input int i);
    int w;
`ifdef ROUNDROBIN_WEIGHT_EN
    w = int'((req >> (5 * i)) & 20'd31);
    return (w == 0) ? 1 : w;
`else
    w = int'(req[0]);
    return 1 + 0 * w;
`endif
  endfunction

  function automatic int m_pick(input int cur, input logic [3:0] emp);
    for (int k = 0; k < 4; k++)
      if (!emp[(cur + k) % 4]) return (cur + k) % 4;
    return cur;
  endfunction

  task automatic tick();
    int g, r, nc, nn;
    g = m_pick(m_cur, empty);
    nc = m_cur; nn = m_cnt;
    if (reset) begin
      nc = 0; nn = m_eff(request, 0);
    end else if (read && empty != 4'hf) begin
      r = (g == m_cur) ? m_cnt : m_eff(request, g);
      if (r <= 1) begin nc = (g + 1) % 4; nn = m_eff(request, nc); end
      else begin nc = g; nn = r - 1; end
    end
    @(posedge clk);
    #1;
    m_cur = nc; m_cnt = nn;
  endtask

  task automatic do_reset(input logic [19:0] req, input logic [3:0] emp);
    request = req; empty = emp; read = 1; reset = 1;
    tick(); tick();
    reset = 0; read = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset({4{5'd1}}, 4'hf);
    n_total++;
    if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else n_pass++;
    n_total++;
    if (pop_id !== 2'd0) $display("FAIL reset_pop_id: got %0d expected 0", pop_id); else n_pass++;
  endtask

  task automatic run_seq(input string name, input int exp[$]);
    read = 1;
    foreach (exp[i]) begin
      #1;
      n_total++;
      if (pop_id !== 2'(exp[i]) || valid !== 1'b1)
        $display("FAIL %s[%0d]: got pop_id=%0d valid=%b expected pop_id=%0d valid=1", name, i, pop_id, valid, exp[i]);
      else n_pass++;
      tick();
    end
    read = 0;
  endtask

  task automatic test_plain_rr();
    do_reset({4{5'd1}}, 4'h0);
    run_seq("plain_rr", '{0, 1, 2, 3, 0});
  endtask

  task automatic test_weighted();
    do_reset({5'd1, 5'd1, 5'd1, 5'd3}, 4'h0);
`ifdef ROUNDROBIN_WEIGHT_EN
    run_seq("weighted", '{0, 0, 0, 1, 2, 3, 0});
`else
    run_seq("weighted", '{0, 1, 2, 3, 0, 1, 2});
`endif
  endtask

  task automatic test_skip_empty();
    do_reset({4{5'd1}}, 4'b1010);
    run_seq("skip_empty", '{0, 2, 0, 2, 0});
  endtask

  task automatic test_zero_latency();
    do_reset({4{5'd1}}, 4'h0);
    read = 1; tick(); read = 0;
    empty = 4'b1101; #1;
    n_total++;
    if (pop_id !== 2'd1) $display("FAIL zl_1101: got %0d expected 1", pop_id); else n_pass++;
    empty = 4'b0101; #1;
    n_total++;
    if (pop_id !== 2'd1) $display("FAIL zl_0101: got %0d expected 1", pop_id); else n_pass++;
    empty = 4'b0010; #1;
    n_total++;
    if (pop_id !== 2'd2) $display("FAIL zl_skip1: got %0d expected 2", pop_id); else n_pass++;
    empty = 4'b1111; #1;
    n_total++;
    if (pop_id !== 2'd1 || valid !== 1'b0)
      $display("FAIL zl_all_empty: got pop_id=%0d valid=%b expected pop_id=1 valid=0", pop_id, valid);
    else n_pass++;
    read = 1; tick(); read = 0;
    empty = 4'h0; tick(); #1;
    n_total++;
    if (pop_id !== 2'd1) $display("FAIL zl_no_state_change: got %0d expected 1", pop_id); else n_pass++;
  endtask

  task automatic test_reset_mid_quantum();
    do_reset({5'd1, 5'd1, 5'd1, 5'd3}, 4'h0);
    read = 1; tick();
    reset = 1; tick();
    reset = 0;
`ifdef ROUNDROBIN_WEIGHT_EN
    run_seq("reset_mid", '{0, 0, 0, 1});
`else
    run_seq("reset_mid", '{0, 1, 2, 3});
`endif
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset({4{5'd1}}, 4'h0);
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 31) == 0);
      read = ($urandom_range(0, 3) != 0);
      empty = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) request = 20'($urandom);
      #1;
      n_total++;
      if (pop_id !== 2'(m_pick(m_cur, empty)) || valid !== (empty != 4'hf)) begin
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: got pop_id=%0d valid=%b expected pop_id=%0d valid=%b",
                   i, pop_id, valid, m_pick(m_cur, empty), empty != 4'hf);
      end else n_pass++;
      tick();
    end
    reset = 0; read = 0;
  endtask

  initial begin
    test_reset();
    test_plain_rr();
    test_weighted();
    test_skip_empty();
    test_zero_latency();
    test_reset_mid_quantum();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/round_robin.md
ROUND_ROBIN -- requirements
Module: round_robin

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled only on rising clk.
REQ-004 request  input  20  four 5-bit weights; W(i) = request[5i+4:5i], i = 0..3.
REQ-005 empty  input  4  per-FIFO empty flags; empty[i] = 1 means FIFO i has no data.
REQ-006 read  input  1  consumer pops FIFO pop_id this cycle; meaningful only when valid = 1.
REQ-007 pop_id  output  2  index of the FIFO currently granted.
REQ-008 valid  output  1  1 when pop_id names a non-empty FIFO.

Function
REQ-009 SHALL hold state cur[1:0] (preferred FIFO) and cnt[4:0] (grants remaining for cur).
REQ-010 Effective weight SHALL be E(i) = W(i) when W(i) != 0, and 1 when W(i) = 0.
REQ-011 valid SHALL be combinational: valid = ~&empty, i.e. at least one FIFO is non-empty.
REQ-012 pop_id SHALL be combinational: cur when empty[cur] = 0; otherwise the first non-empty index in order cur+1, cur+2, cur+3 (mod 4).
REQ-013 When valid = 0, pop_id SHALL equal cur.
REQ-014 Grant latency SHALL be zero cycles: a change on empty is reflected on pop_id/valid in the same cycle.
REQ-015 A pop is a rising clk with read = 1 and valid = 1; read with valid = 0 SHALL be ignored with no state change.
REQ-016 On a pop with g = pop_id, remaining count r SHALL be cnt when g == cur, else E(g).
REQ-017 If r <= 1, the pop SHALL set cur <= g+1 (mod 4) and cnt <= E(g+1).
REQ-018 If r > 1, the pop SHALL set cur <= g and cnt <= r-1.
REQ-019 Without a pop, cur and cnt SHALL hold.
REQ-020 Weights SHALL be sampled only when cnt is loaded; request changes mid-quantum SHALL NOT affect the current cnt.
REQ-021 Skipping empty FIFOs SHALL forfeit their turn with no credit saved.
REQ-022 Wrap-around: index 3 + 1 SHALL be 0.

Reset
REQ-023 While reset = 1 at a rising clk, state SHALL load cur = 0 and cnt = E(0); read SHALL be ignored.
REQ-024 During reset, outputs SHALL still follow REQ-011/012 combinationally from the reset state.
REQ-025 Reset asserted mid-quantum SHALL discard cnt; the first grant after reset SHALL favour FIFO 0.

Configuration
REQ-026 Macro ROUNDROBIN_WEIGHT_EN: when defined, weights SHALL be used per REQ-010.
REQ-027 When ROUNDROBIN_WEIGHT_EN is undefined, E(i) SHALL be 1 for all i, request SHALL be ignored, and the block SHALL perform plain round-robin with one pop per turn.

Verification
REQ-028 reset = 1 for 2 cycles, empty = 4'b1111 -> valid = 0, pop_id = 0.
REQ-029 empty = 0000, all weights 1, read = 1 continuously -> pop_id sequence 0,1,2,3,0.
REQ-030 With WEIGHT_EN, request = {5'd1,5'd1,5'd1,5'd3}, empty = 0000, read = 1 -> pop_id 0,0,0,1,2,3,0.
REQ-031 empty = 4'b1010, read = 1 -> pop_id alternates 0,2,0,2; FIFOs 1 and 3 are never granted.
REQ-032 cur = 1, empty switches 1101 -> 0101 with read = 0 -> pop_id 1 in the same cycle; no state change.
REQ-033 Reset pulsed mid-quantum (FIFO 0, W(0) = 3, after one pop) -> next pops give pop_id 0 three times, then 1.
